// File: rtl/reg_file_gen.sv
// Parametrised 2R/2W register file with optional hard-zero r0, write-to-read
// bypass and a bulk-clear sequencer that stalls writes while it runs.
module reg_file_gen #(
  parameter int DW      = 8,
  parameter int AW      = 3,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] rd_addrA,
  input  logic [AW-1:0] rd_addrB,
  input  logic          wr_en0,
  input  logic [AW-1:0] wr_addr0,
  input  logic [DW-1:0] dat_in0,
  input  logic          wr_en1,
  input  logic [AW-1:0] wr_addr1,
  input  logic [DW-1:0] dat_in1,
  input  logic          clr_req,
  output logic          wr_rdy,
  output logic          busy,
  output logic          clr_done,
  output logic [DW-1:0] datA_out,
  output logic [DW-1:0] datB_out
);

  localparam int            DEPTH    = 2 ** AW;
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [DW-1:0] core_q [DEPTH];
  logic [DW-1:0] core_d [DEPTH];

  logic wr_acc0, wr_acc1;

  assign wr_rdy   = (state_q == S_IDLE);
  assign busy     = (state_q != S_IDLE);
  assign clr_done = (state_q == S_DONE);
  assign wr_acc0  = wr_en0 && wr_rdy;
  assign wr_acc1  = wr_en1 && wr_rdy;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    core_d  = core_q;
    case (state_q)
      S_IDLE: begin
        // Port 1 is applied last so it wins an address collision.
        if (wr_acc0) core_d[wr_addr0] = dat_in0;
        if (wr_acc1) core_d[wr_addr1] = dat_in1;
        if (clr_req) begin
          state_d = S_CLEAR;
          ptr_d   = '0;
        end
      end
      S_CLEAR: begin
        core_d[ptr_q] = '0;
        ptr_d         = ptr_q + 1'b1;
        if (ptr_q == LAST_PTR) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (ZERO_R0 != 0) core_d[0] = '0;
  end

  // NOTE: the storage array is reset here on purpose; async reset must zero
  // every entry, which rules out mapping this array onto a RAM macro.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      for (int i = 0; i < DEPTH; i++) core_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      core_q  <= core_d;
    end
  end

  function automatic logic [DW-1:0] read_port(input logic [AW-1:0] addr);
    logic [DW-1:0] val;
    val = core_q[addr];
    if (BYPASS != 0) begin
      if (wr_acc1 && wr_addr1 == addr)      val = dat_in1;
      else if (wr_acc0 && wr_addr0 == addr) val = dat_in0;
    end
    if (ZERO_R0 != 0 && addr == '0) val = '0;
    if (reset) val = '0;
    return val;
  endfunction

  always_comb begin
    datA_out = read_port(rd_addrA);
    datB_out = read_port(rd_addrB);
  end

endmodule
